// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the multi-cycle control sequencer:
//   - state_t       : sequencer state enum (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//   - ctrl_word_t   : control word latched in DECODE and replayed in later states
//   - CLS_* / SUB_* : opcode class field (top 3 bits) and sub field (low 3 bits)
//   - JUMP_*        : PC source select encodings
//   - ALU_OP_*      : ALU operation class encodings
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // PC source select
  localparam logic [1:0] JUMP_SEQ = 2'b00;
  localparam logic [1:0] JUMP_IMM = 2'b01;
  localparam logic [1:0] JUMP_REG = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALU_OP_REG = 2'b00;
  localparam logic [1:0] ALU_OP_IMM = 2'b01;
  localparam logic [1:0] ALU_OP_ALT = 2'b10;
  localparam logic [1:0] ALU_OP_CMP = 2'b11;

  // Class field values
  localparam logic [2:0] CLS_REG   = 3'b000;
  localparam logic [2:0] CLS_MEM   = 3'b001;
  localparam logic [2:0] CLS_IMM_A = 3'b010;
  localparam logic [2:0] CLS_IMM_B = 3'b011;
  localparam logic [2:0] CLS_ALT   = 3'b100;
  localparam logic [2:0] CLS_ALU1  = 3'b101;
  localparam logic [2:0] CLS_JR    = 3'b110;
  localparam logic [2:0] CLS_J     = 3'b111;

  // Sub field values
  localparam logic [2:0] SUB_LOAD   = 3'b000;
  localparam logic [2:0] SUB_STORE  = 3'b001;
  localparam logic [2:0] SUB_NOP    = 3'b010;
  localparam logic [2:0] SUB_BRANCH = 3'b101;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       mem_to_reg;
    logic       is_load;
    logic       is_store;
    logic       illegal;
    logic [1:0] jump;
    logic [1:0] alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NONE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Purely combinational opcode -> control word decoder.
// Ports:
//   op  in  OP_W         opcode; class = op[OP_W-1:OP_W-3], sub = op[2:0]
//   cw  out ctrl_word_t  decoded control word (no-op pattern is all zero)
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output ctrl_word_t      cw
);

  logic [2:0] cls;
  logic [2:0] sub;

  assign cls = op[OP_W-1 -: 3];
  assign sub = op[2:0];

  // Class selects the instruction family; the memory class and the two
  // immediate classes further split on the sub field.
  always_comb begin
    cw = CTRL_NONE;
    case (cls)
      CLS_REG: begin
        cw.reg_write = 1'b1;
        cw.alu_op    = ALU_OP_REG;
      end
      CLS_MEM: begin
        case (sub)
          SUB_LOAD: begin
            cw.is_load    = 1'b1;
            cw.alu_src    = 1'b1;
            cw.mem_to_reg = 1'b1;
            cw.reg_write  = 1'b1;
          end
          SUB_STORE: begin
            cw.is_store  = 1'b1;
            cw.alu_src   = 1'b1;
            cw.mem_write = 1'b1;
          end
          SUB_NOP: ;
          default: cw.illegal = 1'b1;
        endcase
      end
      CLS_IMM_A, CLS_IMM_B: begin
        if (sub == SUB_BRANCH) begin
          cw.branch = 1'b1;
          cw.alu_op = ALU_OP_CMP;
        end else begin
          cw.alu_src   = 1'b1;
          cw.alu_op    = ALU_OP_IMM;
          cw.reg_write = 1'b1;
        end
      end
      CLS_ALT: begin
        cw.alu_op    = ALU_OP_ALT;
        cw.reg_write = 1'b1;
      end
      CLS_ALU1: begin
        cw.alu_op    = ALU_OP_IMM;
        cw.reg_write = 1'b1;
      end
      CLS_JR:  cw.jump = JUMP_REG;
      default: cw.jump = JUMP_IMM;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// The opcode is decoded and latched in DECODE; every strobe afterwards comes
// from the state and that latched word, so later changes on op are ignored.
// Build option: MULTICYCLE_CTRL_TRAP_EN
//   defined   : illegal opcode parks the sequencer in TRAP until reset
//   undefined : illegal opcode runs as a no-op with a one-cycle illegal flag
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   op                      opcode (sampled in DECODE only)
//   imem_ready, dmem_ready  instruction / data memory handshakes
//   pc_en, ir_load, imem_req, dmem_req, mem_write, mem_to_reg, reg_write,
//   alu_src, branch, jump, alu_op   datapath control strobes
//   retire, retired_cnt     completion pulse and wrapping retire counter
//   illegal                 illegal-opcode flag
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ir_load,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src,
  output logic             branch,
  output logic [1:0]       jump,
  output logic [1:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             illegal
);

  state_t     state;
  state_t     state_next;
  ctrl_word_t cw_dec;
  ctrl_word_t cw_q;
  logic       is_mem;

  ctrl_decode #(.OP_W(OP_W)) u_decode (
    .op (op),
    .cw (cw_dec)
  );

  assign is_mem = cw_q.is_load | cw_q.is_store;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Control word is captured only in DECODE, which is what isolates the
  // rest of the instruction from op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cw_q <= CTRL_NONE;
    else if (state == ST_DECODE)  cw_q <= cw_dec;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
  end

  // Next-state logic. Instructions with neither a memory access nor a
  // register write (branch, jump, no-op, untrapped illegal) finish in EXEC.
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: if (imem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        if (cw_dec.illegal) state_next = ST_TRAP;
        else                state_next = ST_EXEC;
`else
        state_next = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        if (is_mem)              state_next = ST_MEM;
        else if (cw_q.reg_write) state_next = ST_WB;
        else                     state_next = ST_FETCH;
      end
      ST_MEM: begin
        if (dmem_ready) state_next = cw_q.is_load ? ST_WB : ST_FETCH;
      end
      ST_WB: state_next = ST_FETCH;
      ST_TRAP: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        state_next = ST_TRAP;
`else
        state_next = ST_FETCH;
`endif
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // Output decode from state and latched word. The handshake inputs only
  // qualify the strobes that end a wait (ir_load, store completion).
  // Everything is forced low while reset is held.
  always_comb begin
    pc_en      = 1'b0;
    ir_load    = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = JUMP_SEQ;
    alu_op     = ALU_OP_REG;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      ST_EXEC: begin
        alu_src = cw_q.alu_src;
        alu_op  = cw_q.alu_op;
        illegal = cw_q.illegal;
        if (!is_mem && !cw_q.reg_write) begin
          branch = cw_q.branch;
          jump   = cw_q.jump;
          pc_en  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        mem_write = cw_q.mem_write;
        if (dmem_ready && cw_q.is_store) begin
          pc_en  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_WB: begin
        reg_write  = cw_q.reg_write;
        mem_to_reg = cw_q.mem_to_reg;
        pc_en      = 1'b1;
        retire     = 1'b1;
      end
      ST_TRAP: illegal = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      pc_en      = 1'b0;
      ir_load    = 1'b0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      branch     = 1'b0;
      jump       = JUMP_SEQ;
      alu_op     = ALU_OP_REG;
      retire     = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the core, replacing the single-cycle main decoder. It latches the opcode of each fetched instruction and walks a FETCH/DECODE/EXEC/MEM/WB state machine. Per-state control strobes for PC, IR, register file, ALU and data memory are driven from that state machine. Instruction and data memory accesses use a ready handshake, an instruction-retired counter is kept, and illegal opcodes are handled per the build configuration.

## Interface
- `OP_W`, 6: opcode width, ≥6.
  - Class field = `op[OP_W-1:OP_W-3]`.
  - Sub field = `op[2:0]`.
  - Any other bits are ignored.
- `CNT_W`, 16: retired-instruction counter width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  OP_W  opcode from the instruction word; sampled only in DECODE.
- `imem_ready`  in  1  instruction word valid this cycle.
- `dmem_ready`  in  1  data access complete this cycle.
- `pc_en`  out  1  PC update strobe.
- `ir_load`  out  1  instruction-register load strobe.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data memory request.
- `mem_write`  out  1  data memory write, valid with `dmem_req`.
- `mem_to_reg`  out  1  write-back source is memory.
- `reg_write`  out  1  register-file write enable.
- `alu_src`  out  1  ALU B operand is the immediate.
- `branch`  out  1  conditional PC update.
- `jump`  out  2  PC source select:
  - 00 sequential.
  - 01 immediate target.
  - 11 register target.
- `alu_op`  out  2  ALU operation class.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `retired_cnt`  out  CNT_W  count of retired instructions.
- `illegal`  out  1  illegal-opcode flag.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset: state FETCH; every output 0; latched control word 0; `retired_cnt` 0.
- FETCH:
  - Asserts `imem_req`.
  - When `imem_ready`=1, pulses `ir_load` and goes to DECODE.
  - Otherwise holds.
- DECODE: latches the control word from `op` (below), then goes to EXEC. No strobes.
- Decode on the class field:
  - 000: register ALU op, alu_op 00, reg_write.
  - 001, by sub field:
    - 000: load, alu_src, mem_to_reg, reg_write.
    - 001: store, alu_src, mem_write.
    - 010: no-op.
    - Other: illegal.
  - 010/011, by sub field:
    - 101: conditional branch, branch, alu_op 11.
    - Other: immediate ALU op, alu_src, alu_op 01, reg_write.
  - 100: ALU op, alu_op 10, reg_write.
  - 101: ALU op, alu_op 01, reg_write.
  - 110: register jump, jump 11.
  - 111: immediate jump, jump 01.
- EXEC:
  - `alu_src`/`alu_op` are driven.
  - Branch, jump and no-op: `branch`/`jump` driven, `pc_en`=1, retire, then FETCH.
  - ALU ops: go to WB.
  - Load/store: go to MEM.
- MEM:
  - Asserts `dmem_req` (plus `mem_write` for stores) until `dmem_ready`.
  - Store on ready: `pc_en`, retire, then FETCH.
  - Load on ready: go to WB.
- WB: `reg_write` (plus `mem_to_reg` for loads), `pc_en`, retire, then FETCH.
- Outputs are a pure decode of state and latched control word (Moore), so they are glitch-free relative to `op`.
- `retired_cnt` increments on each `retire` and wraps modulo 2^CNT_W.
- `op` changing outside DECODE has no effect.
- Reset mid-instruction returns to FETCH next edge; the partial instruction is not retired.

## Timing
- Cycles per instruction with zero wait states:
  - Branch, jump and no-op: 3.
  - ALU ops and store: 4.
  - Load: 5.
- Each cycle `imem_ready`/`dmem_ready` is low adds exactly one cycle in FETCH/MEM.
- `ir_load` is high for exactly one cycle per fetch.
- `retire` is coincident with `pc_en`.
- `retired_cnt` reflects the retire one cycle after the pulse.

## Configuration
- `MULTICYCLE_CTRL_TRAP_EN` defined:
  - An illegal opcode moves DECODE to TRAP.
  - TRAP sets `illegal`=1 and holds all other strobes 0.
  - TRAP is left only by reset; the instruction is not retired.
- Undefined:
  - An illegal opcode executes as a no-op (3 cycles, retired).
  - `illegal` pulses high for the EXEC cycle only.

## Structure
- Shared package `ctrl_pkg`:
  - State enum.
  - Control-word struct (reg_write, alu_src, branch, mem_write, mem_to_reg, is_load, is_store, illegal, jump, alu_op).
  - Class/sub-field opcode constants.
  - `jump` and `alu_op` encodings.
- Sub-module `ctrl_decode`: combinational opcode-to-control-word function, instantiated once. The FSM and counter stay in the top.

## Test plan
- Reset with `op`=6'b000000 and ready lines high: all outputs 0 during reset. Then FETCH→DECODE→EXEC→WB, `reg_write`=1 in cycle 4, `retire` in cycle 4, `retired_cnt`=1.
- Load `op`=6'b001000 with `dmem_ready` held low for 2 MEM cycles: `dmem_req` high for 3 cycles, `mem_write`=0. Then WB with `mem_to_reg`=1, total 7 cycles.
- Store 6'b001001 followed by branch 6'b010101:
  - Store: `mem_write` with `dmem_req`, retires in cycle 4, no `reg_write`.
  - Branch: `branch`=1, `alu_op`=11, retires in cycle 3.
- Jumps 6'b110000 then 6'b111000: `jump`=11 then 01 on the respective EXEC cycles. `op` toggled during EXEC does not alter outputs.
- Illegal 6'b001111:
  - With the macro: TRAP, `illegal` stays 1, no `retire`. Deasserting `rst_n` mid-TRAP returns to FETCH with `illegal`=0.
  - Without the macro: one-cycle `illegal`, retires as a no-op.
- `CNT_W`=4: 17 retired no-ops (6'b001010) → `retired_cnt`=1 after wrap.
